spi_controller: RTL and testbench
=================================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter CLK_DIV, 4: clk cycles per SCLK half-period; legal range 2..255.
REQ-002 Clocking: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  requester has a write transaction pending.
REQ-006 req_ready  output  1  controller accepts a request this cycle; high only in IDLE.
REQ-007 req_addr  input  7  target register address.
REQ-008 req_data  input  8  register write data.
REQ-009 busy  output  1  high from acceptance until return to IDLE.
REQ-010 done  output  1  one-cycle pulse when a frame completes.
REQ-011 sclk  output  1  SPI clock; idles low (mode 0).
REQ-012 ncs  output  1  active-low chip select; idles high.
REQ-013 copi  output  1  serial data to peripheral, MSB first.

Function
REQ-014 Frame SHALL be 16 bits: bit15 = 1 (write), bits14:8 = req_addr, bits7:0 = req_data.
REQ-015 Handshake: transfer occurs on a clk edge with req_valid && req_ready; addr/data captured into a 16-bit shift register on that edge.
REQ-016 req_valid while req_ready is low SHALL be ignored; the requester holds it until accepted.
REQ-017 States: IDLE, SETUP, SCLK_HI, SCLK_LO, GAP.
REQ-018 IDLE -> SETUP on acceptance; ncs drops and copi = bit15 on the same edge; busy rises.
REQ-019 SETUP lasts CLK_DIV cycles with sclk low, then -> SCLK_HI.
REQ-020 SCLK_HI: sclk high for CLK_DIV cycles, copi stable, then -> SCLK_LO.
REQ-021 SCLK_LO: sclk low for CLK_DIV cycles; copi shifts to the next bit on entry.
REQ-022 SCLK_LO exits to SCLK_HI for rising edges 2..16, or to GAP after the 16th.
REQ-023 Exactly 16 sclk rising edges per frame; copi changes only on sclk falling edges or at SETUP entry.
REQ-024 ncs low time SHALL be exactly 33*CLK_DIV cycles (132 for CLK_DIV = 4).
REQ-025 GAP: ncs high, sclk low, copi 0, for CLK_DIV cycles; done pulses in its first cycle; then -> IDLE with busy low.
REQ-026 A request held through GAP SHALL be accepted in the first IDLE cycle, giving a minimum ncs-high gap of CLK_DIV+1 cycles.
REQ-027 sclk, ncs, copi and done SHALL be driven directly from flops (glitch-free).
REQ-028 Half-period counter width: 8 bits; bit counter: 5 bits.

Reset
REQ-029 While rst_n is low: state IDLE, ncs 1, sclk 0, copi 0, busy 0, done 0, counters 0; req_ready is 1 after release.
REQ-030 Reset mid-frame SHALL raise ncs asynchronously, discard the frame, and produce no done pulse.

Structure
REQ-031 Package spi_ctrl_pkg SHALL hold FRAME_BITS=16, ADDR_W=7, DATA_W=8, WRITE_BIT=1, the state enum, and peripheral register addresses 0x00-0x04 (out enables 7:0/15:8, PWM enables 7:0/15:8, duty cycle).
REQ-032 One sub-module, spi_clk_div: the CLK_DIV half-period tick generator, restarted on acceptance.

Verification (CLK_DIV = 4 unless stated; check against a model of the existing SPI peripheral)
REQ-033 Write addr 0x00, data 0xF0 -> copi sampled on sclk rising edges = 1_0000000_11110000; peripheral out-enable[7:0] = 0xF0; one done pulse.
REQ-034 Write addr 0x04, data 0x80 -> 16 sclk rises, ncs low for 132 cycles, duty register = 0x80.
REQ-035 Hold req_valid for addr 0x02 then 0x03 back-to-back -> second ncs fall exactly 5 cycles after first ncs rise; both registers written.
REQ-036 Assert rst_n low after the 7th sclk rise -> ncs high within the same cycle; no done pulse; peripheral registers unchanged.
REQ-037 CLK_DIV = 2, write addr 0x01, data 0xAA -> ncs low for 66 cycles; correct bits; peripheral register 0x01 = 0xAA.
REQ-038 Pulse req_valid while busy with a different addr -> ignored, no extra frame; req_ready low throughout.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared constants, state encoding and peripheral register map for the SPI write controller.
package spi_ctrl_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam logic        WRITE_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCLK_HI,
    SCLK_LO,
    GAP
  } state_t;

  // Register map of the attached peripheral
  localparam logic [ADDR_W-1:0] REG_OUT_EN_LO = 7'h00;
  localparam logic [ADDR_W-1:0] REG_OUT_EN_HI = 7'h01;
  localparam logic [ADDR_W-1:0] REG_PWM_EN_LO = 7'h02;
  localparam logic [ADDR_W-1:0] REG_PWM_EN_HI = 7'h03;
  localparam logic [ADDR_W-1:0] REG_DUTY      = 7'h04;

  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {WRITE_BIT, addr, data};
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one tick every CLK_DIV clk cycles while running.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || !run || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick = run && !restart && (cnt == LAST);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write-only master: serialises {1, addr, data} MSB first with a guarded chip select.
module spi_controller
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              ncs,
  output logic              copi
);

  state_t                state;
  logic [FRAME_BITS-1:0] shift;
  logic [4:0]            bit_cnt;
  logic                  accept;
  logic                  tick;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (accept),
    .run     (state != IDLE),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      ncs     <= 1'b1;
      copi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shift   <= build_frame(req_addr, req_data);
            copi    <= WRITE_BIT;
            ncs     <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            sclk    <= 1'b1;
            bit_cnt <= bit_cnt + 5'd1;
            state   <= SCLK_HI;
          end
        end
        SCLK_HI: begin
          // Next bit is presented on the falling edge so it is stable for the whole next high phase
          if (tick) begin
            sclk  <= 1'b0;
            shift <= {shift[FRAME_BITS-2:0], 1'b0};
            copi  <= shift[FRAME_BITS-2];
            state <= SCLK_LO;
          end
        end
        SCLK_LO: begin
          if (tick) begin
            if (bit_cnt == 5'(FRAME_BITS)) begin
              ncs   <= 1'b1;
              copi  <= 1'b0;
              done  <= 1'b1;
              state <= GAP;
            end else begin
              sclk    <= 1'b1;
              bit_cnt <= bit_cnt + 5'd1;
              state   <= SCLK_HI;
            end
          end
        end
        GAP: begin
          if (tick) begin
            busy    <= 1'b0;
            bit_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: timing model per instance plus a receiving peripheral model.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready, busy, done, sclk, ncs, copi;
  logic [6:0] req_addr [2];
  logic [7:0] req_data [2];

  int errors = 0;
  int checks = 0;

  // Expected-behaviour model: per instance, cycles since acceptance of the active frame
  bit          act    [2];
  int          k      [2];
  logic [15:0] mframe [2];

  // Peripheral model fed from the serial pins
  logic [7:0]  preg      [2][5];
  logic [15:0] pshift    [2];
  logic [15:0] pword     [2];
  int          pbits     [2];
  int          last_bits [2];
  int          low_cnt   [2];
  int          last_low  [2];
  int          high_cnt  [2];
  int          last_gap  [2];
  int          dones     [2];
  int          frames    [2];
  logic        psclk     [2];
  logic        pncs      [2];

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_data(req_data[0]), .busy(busy[0]), .done(done[0]),
    .sclk(sclk[0]), .ncs(ncs[0]), .copi(copi[0])
  );

  spi_controller #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_data(req_data[1]), .busy(busy[1]), .done(done[1]),
    .sclk(sclk[1]), .ncs(ncs[1]), .copi(copi[1])
  );

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    for (int i = 0; i < 2; i++) begin
      int   d;
      int   p;
      int   bi;
      logic e_ncs, e_sclk, e_copi, e_busy, e_done, e_ready;
      d = div_of(i);
      e_ncs = 1'b1; e_sclk = 1'b0; e_copi = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_ready = 1'b1;
      if (rst_n && act[i]) begin
        e_ready = 1'b0;
        e_busy  = 1'b1;
        if (k[i] < 33 * d) begin
          e_ncs = 1'b0;
          bi = 15;
          if (k[i] >= d) begin
            p      = (k[i] - d) / d;
            e_sclk = (p % 2 == 0);
            bi     = 15 - (p + 1) / 2;
          end
          e_copi = (bi >= 0) ? mframe[i][bi] : 1'b0;
        end else begin
          e_done = (k[i] == 33 * d);
        end
      end
      check($sformatf("ncs[%0d]", i), ncs[i], e_ncs);
      check($sformatf("sclk[%0d]", i), sclk[i], e_sclk);
      check($sformatf("copi[%0d]", i), copi[i], e_copi);
      check($sformatf("busy[%0d]", i), busy[i], e_busy);
      check($sformatf("done[%0d]", i), done[i], e_done);
      if (rst_n) check($sformatf("req_ready[%0d]", i), req_ready[i], e_ready);
    end
  endtask

  task automatic observe_bus();
    for (int i = 0; i < 2; i++) begin
      if (!ncs[i] && pncs[i]) begin
        last_gap[i] = high_cnt[i];
        pbits[i] = 0; pshift[i] = '0; low_cnt[i] = 0;
      end
      if (ncs[i] && !pncs[i]) begin
        int a;
        last_low[i] = low_cnt[i];
        last_bits[i] = pbits[i];
        high_cnt[i] = 0;
        if (pbits[i] == 16) begin
          pword[i] = pshift[i];
          frames[i]++;
          a = int'(pshift[i][14:8]);
          if (pshift[i][15] && a < 5) preg[i][a] = pshift[i][7:0];
        end
      end
      if (!ncs[i]) low_cnt[i]++; else high_cnt[i]++;
      if (!ncs[i] && sclk[i] && !psclk[i]) begin
        pshift[i] = {pshift[i][14:0], copi[i]};
        pbits[i]++;
      end
      if (done[i]) dones[i]++;
      pncs[i] = ncs[i];
      psclk[i] = sclk[i];
    end
  endtask

  task automatic advance_model();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        act[i] = 1'b0;
      end else if (act[i]) begin
        k[i]++;
        if (k[i] == 34 * div_of(i)) act[i] = 1'b0;
      end else if (req_valid[i]) begin
        act[i] = 1'b1;
        k[i] = 0;
        mframe[i] = {1'b1, req_addr[i], req_data[i]};
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_outputs();
    observe_bus();
    @(posedge clk);
    advance_model();
    #2;
  endtask

  task automatic send(input int i, input logic [6:0] a, input logic [7:0] dt);
    bit ok;
    ok = 1'b0;
    req_valid[i] = 1'b1; req_addr[i] = a; req_data[i] = dt;
    for (int n = 0; n < 400; n++) begin
      step();
      if (act[i] && k[i] == 0) begin ok = 1'b1; break; end
    end
    check($sformatf("accept_timeout[%0d]", i), 32'(ok), 32'd1);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      step();
      if (!act[i]) begin ok = 1'b1; break; end
    end
    check($sformatf("idle_timeout[%0d]", i), 32'(ok), 32'd1);
    step(); step();
  endtask

  initial begin
    int f0, d0;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = '0; req_data[i] = '0;
      act[i] = 1'b0; k[i] = 0; mframe[i] = '0;
      pshift[i] = '0; pword[i] = '0; pbits[i] = 0; last_bits[i] = 0;
      low_cnt[i] = 0; last_low[i] = 0; high_cnt[i] = 0; last_gap[i] = -1;
      dones[i] = 0; frames[i] = 0; psclk[i] = 1'b0; pncs[i] = 1'b1;
      for (int r = 0; r < 5; r++) preg[i][r] = 8'h00;
    end

    step(); step();
    check("rst_ncs", 32'(ncs), 32'h3);
    check("rst_sclk", 32'(sclk), 32'h0);
    check("rst_busy_done", 32'({busy, done}), 32'h0);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", 32'(req_ready), 32'h3);

    // Single write, out-enable low byte
    f0 = frames[0]; d0 = dones[0];
    send(0, 7'h00, 8'hF0);
    wait_idle(0);
    check("t1_word", 32'(pword[0]), 32'h80F0);
    check("t1_reg0", 32'(preg[0][0]), 32'hF0);
    check("t1_rises", 32'(last_bits[0]), 32'd16);
    check("t1_ncs_low", 32'(last_low[0]), 32'd132);
    check("t1_done_count", 32'(dones[0] - d0), 32'd1);
    check("t1_frames", 32'(frames[0] - f0), 32'd1);

    // Duty register
    send(0, 7'h04, 8'h80);
    wait_idle(0);
    check("t2_rises", 32'(last_bits[0]), 32'd16);
    check("t2_ncs_low", 32'(last_low[0]), 32'd132);
    check("t2_reg4", 32'(preg[0][4]), 32'h80);

    // Back-to-back with req_valid held across the gap
    send(0, 7'h02, 8'h3C);
    send(0, 7'h03, 8'hC3);
    wait_idle(0);
    check("t3_gap", 32'(last_gap[0]), 32'd5);
    check("t3_reg2", 32'(preg[0][2]), 32'h3C);
    check("t3_reg3", 32'(preg[0][3]), 32'hC3);

    // Reset after the 7th sclk rise
    f0 = frames[0]; d0 = dones[0];
    send(0, 7'h01, 8'h55);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      step();
      if (pbits[0] == 7) begin ok = 1'b1; break; end
    end
    check("t4_seven_rises", 32'(ok), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t4_ncs_async", 32'(ncs[0]), 32'd1);
    check("t4_sclk_async", 32'(sclk[0]), 32'd0);
    step(); step(); step();
    rst_n = 1'b1;
    step(); step();
    check("t4_reg1_kept", 32'(preg[0][1]), 32'h00);
    check("t4_no_done", 32'(dones[0] - d0), 32'd0);
    check("t4_no_frame", 32'(frames[0] - f0), 32'd0);

    // CLK_DIV = 2 instance
    send(1, 7'h01, 8'hAA);
    wait_idle(1);
    check("t5_ncs_low", 32'(last_low[1]), 32'd66);
    check("t5_word", 32'(pword[1]), 32'h81AA);
    check("t5_reg1", 32'(preg[1][1]), 32'hAA);
    check("t5_rises", 32'(last_bits[1]), 32'd16);

    // Requests pulsed while busy must be ignored
    f0 = frames[0];
    send(0, 7'h03, 8'h11);
    for (int j = 0; j < 3; j++) begin
      for (int n = 0; n < 10; n++) step();
      req_valid[0] = 1'b1; req_addr[0] = 7'h04; req_data[0] = 8'h22;
      check("t6_ready_low", 32'(req_ready[0]), 32'd0);
      step();
      req_valid[0] = 1'b0;
    end
    wait_idle(0);
    check("t6_frames", 32'(frames[0] - f0), 32'd1);
    check("t6_reg3", 32'(preg[0][3]), 32'h11);
    check("t6_reg4", 32'(preg[0][4]), 32'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
